wb_trace_fifo: RTL and testbench
================================

Name: wb_trace_fifo

Overview:
- Sits directly downstream of the CPU top and consumes its writeback debug trace: debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata.
- Filters out non-committing cycles and buffers each register-file commit in a FIFO.
- Streams the buffered commits over a valid/ready interface to the trace comparator or host logger.
- Absorbs backpressure and flags lost entries instead of stalling the core.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, minimum 2.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- debug_wb_pc  input  32  PC of the committing instruction.
- debug_wb_rf_we  input  4  per-byte register write enable.
- debug_wb_rf_wnum  input  5  destination register number.
- debug_wb_rf_wdata  input  32  writeback data.
- trace_valid  output  1  head entry available.
- trace_ready  input  1  consumer accepts the head entry.
- trace_pc  output  32  head entry PC.
- trace_wnum  output  5  head entry register number.
- trace_wdata  output  32  head entry data, masked by we (see Behaviour).
- trace_seq  output  16  commit sequence number of the head entry.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: at least one commit was dropped.
- drop_cnt  output  16  number of dropped commits; saturates at 0xFFFF.
- clr_ovf  input  1  synchronous clear of overflow and drop_cnt.

Behaviour:
- Reset (resetn=0, async): pointers=0, count=0, trace_valid=0, overflow=0, drop_cnt=0, seq counter=0. trace_pc, trace_wnum, trace_wdata and trace_seq read 0 while empty.
- Commit detect: a cycle is a commit when debug_wb_rf_we != 0 and debug_wb_rf_wnum != 0. Otherwise the cycle is ignored and seq does not advance.
- Byte masking at capture: each byte i of stored wdata equals debug_wb_rf_wdata byte i if we[i]=1, else 0x00.
- Sequence number: every commit takes the current 16-bit seq value and then increments it, whether or not it is stored. Wraps 0xFFFF->0x0000. Gaps in trace_seq therefore identify drops.
- Push: on a commit with count<DEPTH, the entry is written at wptr and wptr advances mod DEPTH.
- Full: on a commit with count==DEPTH and no pop in the same cycle, the entry is dropped. overflow is set to 1 and drop_cnt increments, saturating at 0xFFFF.
- Full with simultaneous pop (trace_valid & trace_ready): the push is accepted. count stays at DEPTH and nothing is dropped.
- Pop: trace_valid & trace_ready advances rptr.
- Output timing: the output is first-word-fall-through. Head fields come combinationally from the storage at rptr.
- Latency: an entry captured on edge N is visible with trace_valid=1 after edge N, so the consumer can take it in cycle N+1.
- Empty with simultaneous commit: no bypass. trace_valid rises the cycle after the capture.
- Stability: while trace_valid=1 and trace_ready=0, all head fields hold stable.
- Count update: count = count + push_accepted - pop.
- clr_ovf: clears overflow and drop_cnt on the next edge. If a drop occurs in the same cycle, the clear wins and the result is overflow=0, drop_cnt=0.
- Reset mid-operation: all buffered entries are discarded immediately. trace_valid=0 asynchronously.

Decomposition:
- Shared package wb_trace_pkg:
  - trace_entry_t struct {pc[31:0], wnum[4:0], wdata[31:0], seq[15:0]}, 85 bits.
  - SEQ_W=16.
  - DROP_W=16.
- Sub-module sync_fifo_fwft: parameterised by DEPTH and entry width, with async active-low reset. It provides push/full, pop/empty and count. The capture, masking, sequence and overflow logic stays in wb_trace_fifo.

Test Plan:
- Filter: drive commits at pc=0x1c000000 with (we=0xF, wnum=0) and (we=0x0, wnum=3), then (we=0xF, wnum=3, wdata=0x12345678) -> exactly one entry: pc=0x1c000000, wnum=3, wdata=0x12345678, seq=0.
- Masking: we=0x5, wdata=0xAABBCCDD, wnum=7 -> trace_wdata=0x00BB00DD.
- Overflow: trace_ready=0, 20 commits with DEPTH=16 -> count=16, overflow=1, drop_cnt=4. Entries drain with seq 0..15. The next captured commit has seq=20.
- Full with pop: count=16, trace_ready=1 and a commit in the same cycle -> count stays 16, drop_cnt unchanged, the new entry is at the tail.
- Backpressure and wrap: 40 commits with trace_ready toggling every cycle -> outputs in order with contiguous seq, head stable while stalled, pointers wrap correctly. Then 0xFFFF+2 commits with ready=1 -> seq wraps to 0x0000.
- Reset and clear: assert resetn=0 mid-burst with count=5 -> trace_valid=0 and count=0 immediately. Separately, clr_ovf together with a drop -> overflow=0, drop_cnt=0.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared types and helpers for the writeback trace FIFO.
package wb_trace_pkg;

  localparam int unsigned SEQ_W  = 16;
  localparam int unsigned DROP_W = 16;

  typedef struct packed {
    logic [31:0]      pc;
    logic [4:0]       wnum;
    logic [31:0]      wdata;
    logic [SEQ_W-1:0] seq;
  } trace_entry_t;

  localparam int unsigned ENTRY_W = $bits(trace_entry_t);

  // Bytes whose write enable is clear are stored as zero.
  function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [3:0] we);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[8*i +: 8] = we[i] ? d[8*i +: 8] : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_trace_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 85,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  output logic          full_o,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];

  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/wb_trace_fifo.sv
// Captures register-file commits from the CPU writeback trace and streams them
// out over valid/ready; drops (never stalls) when the buffer is full.
module wb_trace_fifo
  import wb_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       debug_wb_pc,
  input  logic [3:0]        debug_wb_rf_we,
  input  logic [4:0]        debug_wb_rf_wnum,
  input  logic [31:0]       debug_wb_rf_wdata,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [31:0]       trace_pc,
  output logic [4:0]        trace_wnum,
  output logic [31:0]       trace_wdata,
  output logic [SEQ_W-1:0]  trace_seq,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              clr_ovf
);

  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              commit, pop, full, empty, push_ok, drop;
  trace_entry_t      in_entry, head;

  assign commit = (debug_wb_rf_we != '0) && (debug_wb_rf_wnum != '0);
  assign pop    = trace_valid && trace_ready;
  assign push_ok = commit && (!full || pop);
  assign drop    = commit && full && !pop;

  always_comb begin
    in_entry.pc    = debug_wb_pc;
    in_entry.wnum  = debug_wb_rf_wnum;
    in_entry.wdata = mask_bytes(debug_wb_rf_wdata, debug_wb_rf_we);
    in_entry.seq   = seq_q;
  end

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (push_ok),
    .din_i   (in_entry),
    .full_o  (full),
    .pop_i   (pop),
    .dout_o  (head),
    .empty_o (empty),
    .count_o (count)
  );

  assign trace_valid = !empty;
  assign trace_pc    = trace_valid ? head.pc    : '0;
  assign trace_wnum  = trace_valid ? head.wnum  : '0;
  assign trace_wdata = trace_valid ? head.wdata : '0;
  assign trace_seq   = trace_valid ? head.seq   : '0;

  // Sequence advances on every commit, stored or dropped, so gaps mark drops.
  always_comb begin
    seq_d  = commit ? seq_q + SEQ_W'(1) : seq_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop) begin
      ovf_d  = 1'b1;
      drop_d = (drop_q == '1) ? drop_q : drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seq_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      seq_q  <= seq_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed self-checking bench for wb_trace_fifo (DEPTH=16).
module tb_wb_trace_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [4:0]  trace_wnum;
  logic [31:0] trace_wdata;
  logic [15:0] trace_seq;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        clr_ovf;

  int unsigned passed = 0;
  int unsigned total  = 0;

  wb_trace_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .trace_valid       (trace_valid),
    .trace_ready       (trace_ready),
    .trace_pc          (trace_pc),
    .trace_wnum        (trace_wnum),
    .trace_wdata       (trace_wdata),
    .trace_seq         (trace_seq),
    .count             (count),
    .overflow          (overflow),
    .drop_cnt          (drop_cnt),
    .clr_ovf           (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [3:0] we,
                       input logic [4:0] wnum, input logic [31:0] wd);
    debug_wb_pc       = pc;
    debug_wb_rf_we    = we;
    debug_wb_rf_wnum  = wnum;
    debug_wb_rf_wdata = wd;
  endtask

  task automatic idle();
    drive(32'h0, 4'h0, 5'd0, 32'h0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    step();
  endtask

  initial begin
    logic [47:0]  q[$];
    logic [47:0]  e;
    logic [15:0]  exp_seq;
    logic         stalled;
    logic [15:0]  prev_seq;
    logic [31:0]  prev_pc;
    int unsigned  c;

    resetn = 1'b0; trace_ready = 1'b0; clr_ovf = 1'b0;
    idle();
    #1;
    chk("rst_valid", trace_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_pc", trace_pc, 0);
    chk("rst_seq", trace_seq, 0);
    step();
    resetn = 1'b1;
    step();

    // Filter: only the third cycle is a commit
    drive(32'h1c000000, 4'hF, 5'd0, 32'h11111111); step();
    drive(32'h1c000000, 4'h0, 5'd3, 32'h22222222); step();
    chk("filter_none", trace_valid, 0);
    drive(32'h1c000000, 4'hF, 5'd3, 32'h12345678); step();
    idle();
    chk("filter_count", count, 1);
    chk("filter_valid", trace_valid, 1);
    chk("filter_pc", trace_pc, 32'h1c000000);
    chk("filter_wnum", trace_wnum, 3);
    chk("filter_wdata", trace_wdata, 32'h12345678);
    chk("filter_seq", trace_seq, 0);
    trace_ready = 1'b1; step(); trace_ready = 1'b0;
    chk("pop_count", count, 0);
    chk("pop_valid", trace_valid, 0);
    chk("empty_pc", trace_pc, 0);

    // Byte masking
    drive(32'h1c000004, 4'h5, 5'd7, 32'hAABBCCDD);
    chk("nobypass_valid", trace_valid, 0);
    step(); idle();
    chk("mask_wdata", trace_wdata, 32'h00BB00DD);
    chk("mask_wnum", trace_wnum, 7);
    chk("mask_seq", trace_seq, 1);
    trace_ready = 1'b1; step(); trace_ready = 1'b0;

    // Overflow: 20 commits into 16 slots with no consumer
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(32'h1c000100 + 32'(4*i), 4'hF, 5'(1 + i % 31), 32'(i));
      step();
    end
    idle();
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_cnt, 4);
    trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain_seq", trace_seq, 64'(i));
      chk("ovf_drain_wdata", trace_wdata, 64'(i));
      step();
    end
    trace_ready = 1'b0;
    chk("ovf_empty", count, 0);
    drive(32'h1c000200, 4'hF, 5'd4, 32'hCAFE0000); step(); idle();
    chk("ovf_next_seq", trace_seq, 20);
    trace_ready = 1'b1; step(); trace_ready = 1'b0;

    // Full with simultaneous pop: seq 21..36 stored, then 37 alongside a pop
    for (int i = 0; i < 16; i++) begin
      drive(32'h1c000300, 4'hF, 5'd5, 32'h100 + 32'(i)); step();
    end
    chk("fp_full", count, 16);
    drive(32'h1c000400, 4'hF, 5'd6, 32'h0000DEAD);
    trace_ready = 1'b1; step();
    trace_ready = 1'b0; idle();
    chk("fp_count", count, 16);
    chk("fp_drop", drop_cnt, 4);
    chk("fp_head_seq", trace_seq, 22);
    trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("fp_drain_seq", trace_seq, 64'(22 + i));
      if (i == 15) begin
        chk("fp_tail_wdata", trace_wdata, 32'h0000DEAD);
        chk("fp_tail_pc", trace_pc, 32'h1c000400);
      end
      step();
    end
    trace_ready = 1'b0;

    // clr_ovf in the same cycle as a drop: clear wins
    for (int i = 0; i < 16; i++) begin
      drive(32'h1c000500, 4'hF, 5'd8, 32'(i)); step();
    end
    drive(32'h1c000600, 4'hF, 5'd8, 32'h1); clr_ovf = 1'b1; step();
    clr_ovf = 1'b0; idle();
    chk("clr_ovf", overflow, 0);
    chk("clr_drop", drop_cnt, 0);
    chk("clr_count", count, 16);
    drive(32'h1c000600, 4'hF, 5'd8, 32'h2); step(); idle();
    chk("drop_after_clr_ovf", overflow, 1);
    chk("drop_after_clr_cnt", drop_cnt, 1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("clr_alone_ovf", overflow, 0);
    chk("clr_alone_drop", drop_cnt, 0);
    trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    trace_ready = 1'b0;
    chk("clr_drained", count, 0);

    // Backpressure: ready toggles, 40 commits over 53 cycles (3 of every 4)
    exp_seq = 16'd56;
    stalled = 1'b0; prev_seq = '0; prev_pc = '0;
    c = 0;
    while (c < 200 && !(c >= 53 && q.size() == 0)) begin
      chk("bp_count", count, 64'(q.size()));
      chk("bp_valid", trace_valid, 64'(q.size() != 0));
      if (q.size() != 0) begin
        e = q[0];
        chk("bp_seq", trace_seq, 64'(e[47:32]));
        chk("bp_wdata", trace_wdata, 64'({16'hB000, e[15:0]}));
      end
      if (stalled) begin
        chk("bp_stable_seq", trace_seq, 64'(prev_seq));
        chk("bp_stable_pc", trace_pc, 64'(prev_pc));
      end
      trace_ready = c[0];
      if (c < 53 && (c % 4) != 3) begin
        drive(32'h1c001000 + 32'(4*c), 4'hF, 5'd9, {16'hB000, 16'(c)});
      end else begin
        idle();
      end
      stalled  = trace_valid && !trace_ready;
      prev_seq = trace_seq;
      prev_pc  = trace_pc;
      if (trace_valid && trace_ready) void'(q.pop_front());
      if (c < 53 && (c % 4) != 3) begin
        q.push_back({exp_seq, 16'h0, 16'(c)});
        exp_seq++;
      end
      step();
      c++;
    end
    trace_ready = 1'b0; idle();
    chk("bp_drained", 64'(q.size()), 0);
    chk("bp_seq_end", 64'(exp_seq), 96);

    // Sequence wrap: 0x10001 commits, consumer always ready
    do_reset();
    trace_ready = 1'b1;
    for (int n = 0; n < 65537; n++) begin
      drive(32'h1c002000, 4'hF, 5'd10, 32'(n));
      if (n == 65536) chk("wrap_pre_seq", trace_seq, 16'hFFFF);
      step();
    end
    idle();
    chk("wrap_seq", trace_seq, 0);
    chk("wrap_wdata", trace_wdata, 32'h00010000);
    chk("wrap_count", count, 1);
    chk("wrap_drop", drop_cnt, 0);
    step();
    trace_ready = 1'b0;

    // Asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) begin
      drive(32'h1c003000, 4'hF, 5'd11, 32'(i)); step();
    end
    idle();
    chk("mid_count", count, 5);
    #3;
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", trace_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_pc", trace_pc, 0);
    step();
    resetn = 1'b1;
    step();
    chk("post_rst_count", count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
